// File: rtl/perf_monitor_if.sv
// perf_monitor_if: control, event and readout signals of the multi-channel performance monitor.
interface perf_monitor_if #(
    parameter int unsigned CHANNELS         = 4,
    parameter int unsigned NUMBER_OF_DIGITS = 8,
    parameter int unsigned PC_WIDTH         = 12
);
    localparam int unsigned CH_SEL_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int unsigned DG_SEL_W = (NUMBER_OF_DIGITS > 1) ? $clog2(NUMBER_OF_DIGITS) : 1;
    localparam int unsigned CNT_W    = 4 * NUMBER_OF_DIGITS;

    logic                start;
    logic [PC_WIDTH-1:0] pc;
    logic [CHANNELS-1:0] event_in;
    logic [CH_SEL_W-1:0] channel_sel;
    logic [DG_SEL_W-1:0] digit_sel;
    logic [CNT_W-1:0]    count_out;
    logic [3:0]          digit_out;
    logic                running;
    logic                finished;
    logic [CHANNELS-1:0] overflow;

    modport master (
        output start, pc, event_in, channel_sel, digit_sel,
        input  count_out, digit_out, running, finished, overflow
    );

    modport slave (
        input  start, pc, event_in, channel_sel, digit_sel,
        output count_out, digit_out, running, finished, overflow
    );
endinterface

// File: rtl/perf_monitor.sv
// perf_monitor: CHANNELS saturating event counters gated by a start / FINAL_PC window,
// with registered channel and digit readout.
// Optional macro PERF_BCD_EN: counters become BCD digit chains saturating at all nines.
module perf_monitor #(
    parameter int unsigned         CHANNELS         = 4,
    parameter int unsigned         NUMBER_OF_DIGITS = 8,
    parameter int unsigned         PC_WIDTH         = 12,
    parameter logic [PC_WIDTH-1:0] FINAL_PC         = PC_WIDTH'(12'hFFF)
) (
    input  logic          clk,
    input  logic          reset,
    perf_monitor_if.slave bus
);
    localparam int unsigned CH_SEL_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int unsigned DG_SEL_W = (NUMBER_OF_DIGITS > 1) ? $clog2(NUMBER_OF_DIGITS) : 1;
    localparam int unsigned CW       = 4 * NUMBER_OF_DIGITS;
`ifdef PERF_BCD_EN
    localparam logic [CW-1:0] CNT_MAX = {NUMBER_OF_DIGITS{4'h9}};
`else
    localparam logic [CW-1:0] CNT_MAX = '1;
`endif

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    state_e              state_q, state_d;
    logic                count_en_c;
    logic [CW-1:0]       cnt_q [CHANNELS];
    logic [CW-1:0]       cnt_d [CHANNELS];
    logic [CHANNELS-1:0] ovf_q, ovf_d;
    logic [CW-1:0]       sel_cnt_c;
    logic [3:0]          sel_dig_c;
    logic [CW-1:0]       count_q;
    logic [3:0]          digit_q;
    logic                running_q, finished_q;

    // Next counter value: binary +1, or BCD ripple with 9 -> 0 carry.
    function automatic logic [CW-1:0] cnt_inc(input logic [CW-1:0] v);
`ifdef PERF_BCD_EN
        logic [CW-1:0] r;
        logic          carry;
        r     = v;
        carry = 1'b1;
        for (int d = 0; d < int'(NUMBER_OF_DIGITS); d++) begin
            if (carry) begin
                if (v[4*d +: 4] == 4'd9) begin
                    r[4*d +: 4] = 4'd0;
                end else begin
                    r[4*d +: 4] = v[4*d +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
`else
        return v + CW'(1);
`endif
    endfunction

    // Window FSM; the final-PC cycle itself is excluded from counting.
    always_comb begin
        state_d    = state_q;
        count_en_c = 1'b0;
        case (state_q)
            IDLE: if (bus.start) state_d = RUN;
            RUN: begin
                if (bus.pc == FINAL_PC) state_d = DONE;
                else                    count_en_c = 1'b1;
            end
            DONE:    state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    // Saturating increments; overflow latches once a counter reaches its maximum.
    always_comb begin
        ovf_d = ovf_q;
        for (int i = 0; i < int'(CHANNELS); i++) begin
            cnt_d[i] = cnt_q[i];
            if (count_en_c && bus.event_in[i]) begin
                if (cnt_q[i] == CNT_MAX) begin
                    ovf_d[i] = 1'b1;
                end else begin
                    cnt_d[i] = cnt_inc(cnt_q[i]);
                    if (cnt_d[i] == CNT_MAX) ovf_d[i] = 1'b1;
                end
            end
        end
    end

    // Readout mux; out-of-range channel or digit selects read zero.
    always_comb begin
        sel_cnt_c = '0;
        sel_dig_c = '0;
        for (int i = 0; i < int'(CHANNELS); i++) begin
            if (bus.channel_sel == CH_SEL_W'(i)) sel_cnt_c = cnt_q[i];
        end
        for (int d = 0; d < int'(NUMBER_OF_DIGITS); d++) begin
            if (bus.digit_sel == DG_SEL_W'(d)) sel_dig_c = sel_cnt_c[4*d +: 4];
        end
    end

    // State, counters, flags and readout registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            ovf_q      <= '0;
            count_q    <= '0;
            digit_q    <= '0;
            running_q  <= 1'b0;
            finished_q <= 1'b0;
            for (int i = 0; i < int'(CHANNELS); i++) cnt_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            ovf_q      <= ovf_d;
            count_q    <= sel_cnt_c;
            digit_q    <= sel_dig_c;
            running_q  <= (state_d == RUN);
            finished_q <= (state_d == DONE);
            for (int i = 0; i < int'(CHANNELS); i++) cnt_q[i] <= cnt_d[i];
        end
    end

    assign bus.count_out = count_q;
    assign bus.digit_out = digit_q;
    assign bus.running   = running_q;
    assign bus.finished  = finished_q;
    assign bus.overflow  = ovf_q;
endmodule

// File: tb/tb_perf_monitor.sv
// tb_perf_monitor: randomized scoreboard bench; a numeric reference model predicts every
// post-edge output and a negedge monitor compares the DUT against the queued predictions.
module tb_perf_monitor;
    localparam int unsigned    CH = 3;
    localparam int unsigned    ND = 3;
    localparam int unsigned    PW = 12;
    localparam int unsigned    CW = 4 * ND;
    localparam logic [PW-1:0]  FIN = 12'hFFF;
`ifdef PERF_BCD_EN
    localparam longint MAXN = 999;
`else
    localparam longint MAXN = 4095;
`endif

    typedef struct {
        logic [CW-1:0] cnt;
        logic [3:0]    dig;
        logic          run;
        logic          fin;
        logic [CH-1:0] ovf;
    } exp_t;

    logic   clk = 1'b0;
    logic   reset;
    exp_t   sb[$];
    exp_t   me;
    int     checks = 0;
    int     errors = 0;
    longint m_cnt [CH];
    bit     m_run, m_done;

    always #5 clk = ~clk;

    perf_monitor_if #(.CHANNELS(CH), .NUMBER_OF_DIGITS(ND), .PC_WIDTH(PW)) bus ();

    perf_monitor #(
        .CHANNELS(CH), .NUMBER_OF_DIGITS(ND), .PC_WIDTH(PW), .FINAL_PC(FIN)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    // Count value as it appears on the counter bits.
    function automatic logic [CW-1:0] enc(input longint n);
`ifdef PERF_BCD_EN
        logic [CW-1:0] r;
        longint        v;
        r = '0;
        v = n;
        for (int d = 0; d < int'(ND); d++) begin
            r[4*d +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
`else
        return CW'(n);
`endif
    endfunction

    function automatic logic [PW-1:0] cpc();
        return PW'($urandom_range(0, 4094));
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, req, $time);
        end
    endtask

    // One clock: apply inputs, predict outputs after the edge, queue the prediction.
    task automatic cyc(input bit rst, input bit st, input logic [PW-1:0] p,
                       input logic [CH-1:0] ev, input logic [1:0] cs, input logic [1:0] ds);
        exp_t          e;
        logic [CW-1:0] v;
        reset           = rst;
        bus.start       = st;
        bus.pc          = p;
        bus.event_in    = ev;
        bus.channel_sel = cs;
        bus.digit_sel   = ds;
        if (rst) begin
            for (int i = 0; i < int'(CH); i++) m_cnt[i] = 0;
            m_run  = 1'b0;
            m_done = 1'b0;
            e.cnt  = '0;
            e.dig  = '0;
            e.run  = 1'b0;
            e.fin  = 1'b0;
            e.ovf  = '0;
        end else begin
            if (int'(cs) < int'(CH)) v = enc(m_cnt[cs]);
            else                     v = '0;
            e.cnt = v;
            e.dig = (int'(ds) < int'(ND)) ? 4'(v >> (4 * int'(ds))) : 4'h0;
            if (m_run && p != FIN) begin
                for (int i = 0; i < int'(CH); i++)
                    if (ev[i] && m_cnt[i] < MAXN) m_cnt[i]++;
            end
            if (!m_run && !m_done && st) begin
                m_run = 1'b1;
            end else if (m_run && p == FIN) begin
                m_run  = 1'b0;
                m_done = 1'b1;
            end
            e.run = m_run;
            e.fin = m_done;
            for (int i = 0; i < int'(CH); i++) e.ovf[i] = (m_cnt[i] == MAXN);
        end
        sb.push_back(e);
        @(posedge clk);
        @(negedge clk);
    endtask

    // Monitor: every settled cycle is compared against the oldest prediction.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            me = sb.pop_front();
            chk("count_out", 32'(bus.count_out), 32'(me.cnt));
            chk("digit_out", 32'(bus.digit_out), 32'(me.dig));
            chk("running",   32'(bus.running),   32'(me.run));
            chk("finished",  32'(bus.finished),  32'(me.fin));
            chk("overflow",  32'(bus.overflow),  32'(me.ovf));
        end
    end

    initial begin
        // Cycle count over a 100-cycle window, then ignored start/events in DONE.
        repeat (3) cyc(1, 0, 0, '0, 0, 0);
        repeat (2) cyc(0, 0, FIN, 3'b001, 0, 0);
        cyc(0, 1, cpc(), 3'b001, 0, 0);
        repeat (100) cyc(0, 0, cpc(), 3'b001, 0, 2'($urandom_range(0, 2)));
        cyc(0, 0, FIN, 3'b001, 0, 0);
        for (int k = 0; k < 6; k++)
            cyc(0, k[0], cpc(), 3'($urandom), 0, 2'(k % 3));

        // ch1 toggles starting high over 20 counted cycles.
        cyc(1, 0, 0, '0, 0, 0);
        cyc(0, 1, cpc(), 3'b011, 0, 0);
        for (int k = 0; k < 20; k++)
            cyc(0, 0, cpc(), {1'b0, ~k[0], 1'b1}, 2'(k % 2), 0);
        cyc(0, 0, FIN, 3'b011, 1, 0);
        cyc(0, 0, cpc(), '0, 1, 0);
        cyc(0, 0, cpc(), '0, 0, 1);
        cyc(0, 0, cpc(), '0, 1, 0);

        // Saturation on ch0, held well past the maximum.
        cyc(1, 0, 0, '0, 0, 0);
        cyc(0, 1, cpc(), 3'b001, 0, 0);
        repeat (4200) cyc(0, 0, cpc(), 3'b001, 0, 2'($urandom_range(0, 2)));
        cyc(0, 0, FIN, 3'b001, 0, 0);
        cyc(0, 0, cpc(), '0, 0, 2);

        // start together with FINAL_PC in IDLE, then FINAL_PC closes with zero counts.
        cyc(1, 0, 0, '0, 0, 0);
        cyc(0, 1, FIN, 3'b111, 0, 0);
        cyc(0, 0, FIN, 3'b111, 0, 0);
        cyc(0, 0, cpc(), 3'b111, 0, 0);
        cyc(0, 0, cpc(), 3'b111, 2, 0);

        // Reset in the middle of a run, then a fresh window.
        cyc(1, 0, 0, '0, 0, 0);
        cyc(0, 1, cpc(), '0, 0, 0);
        repeat (50) cyc(0, 0, cpc(), 3'($urandom), 2'($urandom_range(0, 2)), 0);
        cyc(1, 0, cpc(), 3'b111, 0, 0);
        cyc(0, 0, cpc(), 3'b111, 1, 0);
        cyc(0, 1, cpc(), 3'b111, 0, 0);
        repeat (30) cyc(0, 0, cpc(), 3'($urandom), 2'($urandom_range(0, 2)), 0);
        cyc(0, 0, FIN, '0, 2, 0);

        // ch2 = 0xA5C events, digit 1 readout and out-of-range selects.
        cyc(1, 0, 0, '0, 0, 0);
        cyc(0, 1, cpc(), 3'b100, 0, 0);
        repeat (2652) cyc(0, 0, cpc(), 3'b100, 2, 0);
        cyc(0, 0, FIN, 3'b100, 2, 1);
        cyc(0, 0, cpc(), '0, 2, 1);
        cyc(0, 0, cpc(), '0, 2, 1);
        cyc(0, 0, cpc(), '0, 3, 1);
        cyc(0, 0, cpc(), '0, 2, 3);
        cyc(0, 0, cpc(), '0, 2, 0);

        // Fully random traffic including sporadic resets, starts and FINAL_PC.
        cyc(1, 0, 0, '0, 0, 0);
        repeat (600)
            cyc(($urandom_range(0, 99) == 0), ($urandom_range(0, 9) == 0),
                ($urandom_range(0, 29) == 0) ? FIN : cpc(),
                3'($urandom), 2'($urandom), 2'($urandom));

        repeat (2) @(negedge clk);
        #1;
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
